i2c_master: RTL and testbench

- Byte-level I2C bus controller: the initiator that drives SCL, generates START/STOP and addresses a target such as our i2c_slave.
- The user side uses the same strobe style as i2c_slave:
  - a FIFO-pop pair (wr_data/wr/wr_en) supplies bytes to transmit;
  - a push pair (rd_data/rd) delivers received bytes.
- Sits between a command source (buttons/FSM/host logic) and the open-drain pads. Lets a second board, or a loopback bench, exercise the existing slave.

---
 rtl/i2c_master.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// Byte-level I2C initiator: generates START/STOP, clocks SCL in four quarters per bit,
// moves bytes through a pop/push strobe interface and supports target clock stretching.
module i2c_master #(
  parameter int unsigned CLK_DIV = 30,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       addr,
  input  logic             rw,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  output logic             wr,
  output logic [7:0]       rd_data,
  output logic             rd,
  output logic             busy,
  output logic             done,
  output logic             nack,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             scl_oe,
  output logic             sda_oe
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StWrite,
    StWack,
    StRead,
    StRack,
    StStop
  } state_e;

  state_e           state_q;
  logic [7:0]       div_q;
  logic [1:0]       qtr_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [LEN_W-1:0] cnt_q;
  logic             rw_q;
  logic             smp_q;
  logic             load_q;

  logic stretch;
  logic div_end;

  // A target holding SCL low while we have released it freezes the bit timing.
  assign stretch = qtr_q[1] && !scl_oe && !scl_in;
  assign div_end = (div_q == DivLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      smp_q   <= 1'b0;
      load_q  <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      wr      <= 1'b0;
      rd      <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      wr   <= 1'b0;
      rd   <= 1'b0;
      done <= 1'b0;
      if (state_q == StIdle) begin
        scl_oe <= 1'b0;
        sda_oe <= 1'b0;
        div_q  <= '0;
        qtr_q  <= '0;
        if (start) begin
          shift_q <= {addr, rw};
          rw_q    <= rw;
          cnt_q   <= len;
          nack    <= 1'b0;
          busy    <= 1'b1;
          state_q <= StStart;
        end
      end else if (load_q) begin
        // Byte boundary of a write: SCL stays low until the FIFO has data.
        if (wr_en) begin
          wr      <= 1'b1;
          shift_q <= wr_data;
          sda_oe  <= !wr_data[7];
          load_q  <= 1'b0;
        end
      end else if (stretch) begin
        div_q <= div_q;
      end else if (!div_end) begin
        div_q <= div_q + 8'd1;
      end else begin
        div_q <= '0;
        qtr_q <= qtr_q + 2'd1;
        unique case (qtr_q)
          2'd0: begin
          end
          2'd1: begin
            scl_oe <= 1'b0;
            if (state_q == StStart) sda_oe <= 1'b1;
          end
          2'd2: begin
            if (state_q == StStop) begin
              sda_oe <= 1'b0;
            end else begin
              smp_q <= sda_in;
              if (state_q == StRead) begin
                shift_q <= {shift_q[6:0], sda_in};
                if (bit_q == 3'd0) begin
                  rd_data <= {shift_q[6:0], sda_in};
                  rd      <= 1'b1;
                end
              end
            end
          end
          2'd3: begin
            scl_oe <= (state_q != StStop);
            unique case (state_q)
              StStart: begin
                state_q <= StAddr;
                bit_q   <= 3'd7;
                sda_oe  <= !shift_q[7];
              end
              StAddr, StWrite: begin
                if (bit_q == 3'd0) begin
                  state_q <= (state_q == StAddr) ? StAddrAck : StWack;
                  sda_oe  <= 1'b0;
                end else begin
                  bit_q   <= bit_q - 3'd1;
                  shift_q <= {shift_q[6:0], 1'b0};
                  sda_oe  <= !shift_q[6];
                end
              end
              StAddrAck: begin
                if (smp_q || cnt_q == '0) begin
                  nack    <= smp_q;
                  state_q <= StStop;
                  sda_oe  <= 1'b1;
                end else begin
                  state_q <= rw_q ? StRead : StWrite;
                  bit_q   <= 3'd7;
                  load_q  <= !rw_q;
                  sda_oe  <= 1'b0;
                end
              end
              StWack: begin
                if (smp_q || cnt_q == LEN_W'(1)) begin
                  nack    <= smp_q;
                  state_q <= StStop;
                  sda_oe  <= 1'b1;
                end else begin
                  state_q <= StWrite;
                  bit_q   <= 3'd7;
                  load_q  <= 1'b1;
                  sda_oe  <= 1'b0;
                end
                cnt_q <= cnt_q - LEN_W'(1);
              end
              StRead: begin
                if (bit_q == 3'd0) begin
                  state_q <= StRack;
                  // ACK every byte except the last one requested.
                  sda_oe  <= (cnt_q > LEN_W'(1));
                end else begin
                  bit_q  <= bit_q - 3'd1;
                  sda_oe <= 1'b0;
                end
              end
              StRack: begin
                cnt_q <= cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                  state_q <= StStop;
                  sda_oe  <= 1'b1;
                end else begin
                  state_q <= StRead;
                  bit_q   <= 3'd7;
                  sda_oe  <= 1'b0;
                end
              end
              StStop: begin
                state_q <= StIdle;
                done    <= 1'b1;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
              end
              default: state_q <= StIdle;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Randomised bench for i2c_master: a behavioural target/bus monitor decodes the wire-level
// transcript, which is compared against an expected transcript built from the protocol rules.
module tb_i2c_master;

  localparam int          Div     = 4;
  localparam logic [6:0]  SlvAddr = 7'h42;
  localparam logic [11:0] EvStart = 12'h800;
  localparam logic [11:0] EvStop  = 12'h900;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       start   = 1'b0;
  logic [6:0] addr    = 7'h00;
  logic       rw      = 1'b0;
  logic [7:0] len     = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en   = 1'b0;
  logic       wr, rd, busy, done, nack, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic       scl_in, sda_in;
  logic       scl_hold = 1'b0;
  logic       sda_low  = 1'b0;

  assign scl_in = !(scl_oe || scl_hold);
  assign sda_in = !(sda_oe || sda_low);

  always #5 clk = ~clk;

  i2c_master #(.CLK_DIV(Div), .LEN_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .addr   (addr),
    .rw     (rw),
    .len    (len),
    .wr_data(wr_data),
    .wr_en  (wr_en),
    .wr     (wr),
    .rd_data(rd_data),
    .rd     (rd),
    .busy   (busy),
    .done   (done),
    .nack   (nack),
    .scl_in (scl_in),
    .sda_in (sda_in),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] bus_log[$];
  logic [7:0]  fifo[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  pat[$];
  int   wr_cnt = 0, done_cnt = 0, both_cnt = 0, hi_len = 0, lo_len = 0, lo_max = 0;
  int   hi_bad = 0, bitn = 0, hold_cnt = 0, stall_cnt = 0;
  logic scl_p = 1'b1, sda_p = 1'b1, hi_valid = 1'b0, is_addr = 1'b0, addressed = 1'b0;
  logic dir_rd = 1'b0, rd_active = 1'b0, slave_en = 1'b0;
  logic stretch_en = 1'b0, stretch_done = 1'b0, stall_en = 1'b0, stall_done = 1'b0;
  logic [7:0] sh = 8'h00, txb = 8'hFF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of the target model: sample the bus on the falling clk edge, then update drives.
  task automatic tick();
    logic s, d;
    @(negedge clk);
    s = scl_in;
    d = sda_in;
    if (hold_cnt > 0) hold_cnt--;
    if (stall_cnt > 0) stall_cnt--;
    if (wr) begin
      wr_cnt++;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    if (rd) rd_log.push_back(rd_data);
    if (wr && rd) both_cnt++;
    if (done) done_cnt++;
    if (s && scl_p && (d != sda_p)) begin
      hi_len++;
      if (!d) begin
        bus_log.push_back(EvStart);
        bitn      = 0;
        is_addr   = 1'b1;
        addressed = 1'b0;
        rd_active = 1'b0;
      end else begin
        bus_log.push_back(EvStop);
      end
      hi_valid = 1'b0;
    end else if (s && !scl_p) begin
      hi_len   = 1;
      hi_valid = 1'b1;
      if (bitn < 8) begin
        sh = {sh[6:0], d};
        bitn++;
      end else begin
        bus_log.push_back({3'b000, d, sh});
        bitn = 0;
        if (is_addr) begin
          is_addr   = 1'b0;
          addressed = slave_en && (sh[7:1] == SlvAddr);
          dir_rd    = sh[0];
          rd_active = addressed && dir_rd;
        end else begin
          if (dir_rd && d) rd_active = 1'b0;
          if (stall_en && !stall_done) begin
            stall_cnt  = 500;
            stall_done = 1'b1;
          end
        end
      end
    end else if (s) begin
      hi_len++;
    end else if (scl_p) begin
      if (hi_valid && (hi_len < 2 * Div - 1 || hi_len > 2 * Div)) hi_bad++;
      hi_valid = 1'b0;
      lo_len   = 1;
      sda_low  = 1'b0;
      if (bitn == 8) begin
        sda_low = is_addr ? (slave_en && (sh[7:1] == SlvAddr)) : (addressed && !dir_rd);
      end else if (rd_active) begin
        if (bitn == 0) begin
          if (tx_q.size() > 0) txb = tx_q.pop_front();
          else txb = 8'hFF;
        end
        sda_low = !txb[7-bitn];
      end
      if (stretch_en && !stretch_done && bitn == 3) begin
        hold_cnt     = 200;
        stretch_done = 1'b1;
      end
    end else begin
      lo_len++;
      if (lo_len > lo_max) lo_max = lo_len;
    end
    scl_hold = (hold_cnt > 0);
    scl_p    = s;
    sda_p    = d;
    wr_en    = (fifo.size() > 0) && (stall_cnt == 0);
    wr_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic clear_target();
    sda_low   = 1'b0;
    scl_hold  = 1'b0;
    hold_cnt  = 0;
    stall_cnt = 0;
    bitn      = 0;
    is_addr   = 1'b0;
    addressed = 1'b0;
    rd_active = 1'b0;
  endtask

  // mode: 0 plain, 1 clock stretch, 2 FIFO stall, 3 start pulse while busy
  task automatic run_xfer(input string tag, input logic [6:0] a, input logic r, input int n,
                          input logic present, input int mode);
    logic [11:0] exp_log[$];
    logic [7:0]  exp_rd[$];
    logic        hit;
    int          exp_wr, cyc, m;
    hit = present && (a == SlvAddr);
    while (pat.size() < n) pat.push_back(8'($urandom));
    fifo.delete();
    tx_q.delete();
    exp_log.push_back(EvStart);
    exp_log.push_back({3'b000, !hit, a, r});
    for (int i = 0; i < n; i++) begin
      if (r) tx_q.push_back(pat[i]);
      else fifo.push_back(pat[i]);
      if (hit) begin
        exp_log.push_back({3'b000, r && (i == n - 1), pat[i]});
        if (r) exp_rd.push_back(pat[i]);
      end
    end
    exp_log.push_back(EvStop);
    exp_wr = (hit && !r) ? n : 0;
    bus_log.delete();
    rd_log.delete();
    wr_cnt = 0; done_cnt = 0; both_cnt = 0; lo_max = 0; hi_bad = 0;
    slave_en = present;
    stretch_en = (mode == 1); stretch_done = 1'b0;
    stall_en = (mode == 2); stall_done = 1'b0;
    addr = a; rw = r; len = 8'(n); start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, " busy_on_accept"}, busy, 1);
    check_eq({tag, " nack_cleared"}, nack, 0);
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      tick();
      cyc++;
      if (mode == 3 && cyc == 40) begin
        addr = 7'h15; rw = !r; len = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) tick();
    check_eq({tag, " done_pulses"}, done_cnt, 1);
    check_eq({tag, " busy_after"}, busy, 0);
    check_eq({tag, " nack"}, nack, !hit);
    check_eq({tag, " log_len"}, bus_log.size(), exp_log.size());
    m = (bus_log.size() < exp_log.size()) ? bus_log.size() : exp_log.size();
    for (int i = 0; i < m; i++) check_eq($sformatf("%s log%0d", tag, i), bus_log[i], exp_log[i]);
    check_eq({tag, " wr_pulses"}, wr_cnt, exp_wr);
    check_eq({tag, " rd_pulses"}, rd_log.size(), exp_rd.size());
    m = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
    for (int i = 0; i < m; i++) check_eq($sformatf("%s rd%0d", tag, i), rd_log[i], exp_rd[i]);
    check_eq({tag, " wr_rd_overlap"}, both_cnt, 0);
    check_eq({tag, " scl_high_time"}, hi_bad, 0);
    if (mode == 1) check_eq({tag, " stretched_low"}, lo_max >= 200, 1);
    if (mode == 2) check_eq({tag, " stalled_low"}, lo_max >= 450, 1);
    pat.delete();
  endtask

  initial begin
    int cyc;
    logic [6:0] a;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    tick();
    check_eq("rst scl_oe", scl_oe, 0);
    check_eq("rst sda_oe", sda_oe, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst nack", nack, 0);
    check_eq("rst wr", wr, 0);
    check_eq("rst rd", rd, 0);
    check_eq("rst rd_data", rd_data, 0);

    pat.push_back(8'hA5); pat.push_back(8'h3C);
    run_xfer("wr2", SlvAddr, 1'b0, 2, 1'b1, 0);
    pat.push_back(8'h11); pat.push_back(8'h22);
    run_xfer("rd2", SlvAddr, 1'b1, 2, 1'b1, 0);
    run_xfer("addr_nack", SlvAddr, 1'b0, 2, 1'b0, 0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("nack_held", nack, 1);
    run_xfer("probe", SlvAddr, 1'b0, 0, 1'b1, 0);
    run_xfer("stretch", SlvAddr, 1'b0, 2, 1'b1, 1);
    run_xfer("stall", SlvAddr, 1'b0, 2, 1'b1, 2);
    run_xfer("start_busy", SlvAddr, 1'b0, 2, 1'b1, 3);

    // Reset in the middle of the address byte.
    pat.push_back(8'h5A); pat.push_back(8'hC3);
    fifo.delete();
    for (int i = 0; i < 2; i++) fifo.push_back(pat[i]);
    pat.delete();
    slave_en = 1'b1; done_cnt = 0;
    addr = SlvAddr; rw = 1'b0; len = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    cyc = 0;
    while (!scl_oe && cyc < 50) begin
      tick();
      cyc++;
    end
    rst = 1'b1;
    tick();
    check_eq("midrst scl_oe", scl_oe, 0);
    check_eq("midrst sda_oe", sda_oe, 0);
    check_eq("midrst busy", busy, 0);
    rst = 1'b0;
    clear_target();
    bus_log.delete();
    for (int i = 0; i < 10; i++) tick();
    check_eq("midrst no_stop", bus_log.size(), 0);
    check_eq("midrst no_done", done_cnt, 0);

    for (int t = 0; t < 16; t++) begin
      a = ($urandom_range(0, 3) != 0) ? SlvAddr : 7'(7'h10 + $urandom_range(0, 15));
      run_xfer($sformatf("rnd%0d", t), a, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               $urandom_range(0, 4) != 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
